// File: rtl/ex_result_buf.sv
// Execute-stage result buffer: 2-entry in-order skid buffer between ALU and memory stage,
// plus the architectural condition-code register and registered branch-condition evaluation.
module ex_result_buf #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_result,
  input  logic             in_z,
  input  logic             in_v,
  input  logic             in_n,
  input  logic             in_flag_we,
  input  logic [2:0]       in_rd,
  input  logic             in_rd_we,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [2:0]       out_rd,
  output logic             out_rd_we,
  input  logic             flush,
  input  logic             br_eval,
  input  logic [2:0]       br_cond,
  output logic             br_valid,
  output logic             br_taken,
  output logic [2:0]       flags
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic [2:0]       rd;
    logic             rd_we;
  } entry_t;

  localparam entry_t ENTRY_ZERO = '{result: {WIDTH{1'b0}}, rd: 3'd0, rd_we: 1'b0};

  // Condition select over flags packed as {z,v,n}; unused encodings never branch.
  function automatic logic cond_eval(input logic [2:0] sel, input logic [2:0] f);
    logic z;
    logic v;
    logic n;
    logic res;
    z = f[2];
    v = f[1];
    n = f[0];
    case (sel)
      3'b000:  res = z;
      3'b001:  res = ~z;
      3'b010:  res = n ^ v;
      3'b011:  res = ~(n ^ v);
      3'b100:  res = v;
      3'b101:  res = 1'b1;
      3'b110:  res = 1'b0;
      3'b111:  res = 1'b0;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  state_t      state_r;
  logic        out_valid_r;
  entry_t      head_r;
  entry_t      skid_r;
  logic [2:0]  flags_r;
  logic        br_valid_r;
  logic        br_taken_r;

  logic        in_ready_s;
  logic        push_s;
  logic        pop_s;
  entry_t      in_entry_s;
  logic [2:0]  in_flags_s;
  logic [2:0]  eval_flags_s;

  // Handshake qualification and same-cycle flag forwarding for branch evaluation.
  always_comb begin
    in_ready_s   = 1'b0;
    push_s       = 1'b0;
    pop_s        = 1'b0;
    eval_flags_s = flags_r;
    in_entry_s   = '{result: in_result, rd: in_rd, rd_we: in_rd_we};
    in_flags_s   = {in_z, in_v, in_n};
    if (rst) begin
      in_ready_s = 1'b0;
    end else begin
      in_ready_s = (state_r != ST_TWO);
    end
    push_s = in_valid & in_ready_s & ~flush;
    pop_s  = out_valid_r & out_ready;
    if (push_s && in_flag_we) begin
      eval_flags_s = in_flags_s;
    end else begin
      eval_flags_s = flags_r;
    end
  end

  // Buffer occupancy and entry storage; the head register always holds the oldest entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_EMPTY;
      out_valid_r <= 1'b0;
      head_r      <= ENTRY_ZERO;
      skid_r      <= ENTRY_ZERO;
    end else if (flush) begin
      state_r     <= ST_EMPTY;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (push_s) begin
            head_r      <= in_entry_s;
            state_r     <= ST_ONE;
            out_valid_r <= 1'b1;
          end
        end
        ST_ONE: begin
          if (push_s && pop_s) begin
            head_r <= in_entry_s;
          end else if (push_s) begin
            skid_r      <= in_entry_s;
            state_r     <= ST_TWO;
            out_valid_r <= 1'b1;
          end else if (pop_s) begin
            state_r     <= ST_EMPTY;
            out_valid_r <= 1'b0;
          end
        end
        ST_TWO: begin
          if (pop_s) begin
            head_r      <= skid_r;
            state_r     <= ST_ONE;
            out_valid_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= ST_EMPTY;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  // Condition codes change only on an accepted flag-writing push; flush leaves them alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      flags_r <= 3'b000;
    end else if (push_s && in_flag_we) begin
      flags_r <= in_flags_s;
    end
  end

  // Branch result is registered one cycle after the request and held between requests.
  always_ff @(posedge clk) begin
    if (rst) begin
      br_valid_r <= 1'b0;
      br_taken_r <= 1'b0;
    end else begin
      br_valid_r <= br_eval;
      if (br_eval) begin
        br_taken_r <= cond_eval(br_cond, eval_flags_s);
      end
    end
  end

  assign in_ready   = in_ready_s;
  assign out_valid  = out_valid_r;
  assign out_result = head_r.result;
  assign out_rd     = head_r.rd;
  assign out_rd_we  = head_r.rd_we;
  assign flags      = flags_r;
  assign br_valid   = br_valid_r;
  assign br_taken   = br_taken_r;

endmodule

// File: tb/tb_ex_result_buf.sv
// Self-checking bench for ex_result_buf: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_ex_result_buf;
  localparam int W = 16;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_result;
  logic         in_z, in_v, in_n;
  logic         in_flag_we;
  logic [2:0]   in_rd;
  logic         in_rd_we;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic [2:0]   out_rd;
  logic         out_rd_we;
  logic         flush;
  logic         br_eval;
  logic [2:0]   br_cond;
  logic         br_valid;
  logic         br_taken;
  logic [2:0]   flags;

  int n_vec = 0;
  int n_err = 0;

  ex_result_buf #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_z(in_z), .in_v(in_v), .in_n(in_n), .in_flag_we(in_flag_we),
    .in_rd(in_rd), .in_rd_we(in_rd_we),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_rd(out_rd), .out_rd_we(out_rd_we),
    .flush(flush), .br_eval(br_eval), .br_cond(br_cond),
    .br_valid(br_valid), .br_taken(br_taken), .flags(flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a FIFO of {rd_we, rd, result} capped at two entries.
  logic [W+3:0] q[$];
  logic [2:0]   m_flags = 3'b000;
  logic         m_brv = 1'b0;
  logic         m_brt = 1'b0;
  logic         m_ready_pre;
  logic         ready_obs;

  function automatic logic m_cond(input logic [2:0] c, input logic [2:0] f);
    logic z, v, n;
    z = f[2]; v = f[1]; n = f[0];
    if (c == 3'd0) return z;
    if (c == 3'd1) return !z;
    if (c == 3'd2) return n != v;
    if (c == 3'd3) return n == v;
    if (c == 3'd4) return v;
    if (c == 3'd5) return 1'b1;
    return 1'b0;
  endfunction

  // Advance one clock: sample in_ready mid-cycle, update the model, land #1 after the edge.
  task automatic tick();
    logic push, pop;
    logic [2:0] ef;
    @(negedge clk);
    ready_obs   = in_ready;
    m_ready_pre = !rst && (q.size() < 2);
    push = in_valid && m_ready_pre && !flush;
    pop  = !rst && (q.size() > 0) && out_ready;
    ef   = (push && in_flag_we) ? {in_z, in_v, in_n} : m_flags;
    if (rst) begin
      q.delete();
      m_flags = 3'b000;
      m_brv = 1'b0;
      m_brt = 1'b0;
    end else begin
      if (pop) void'(q.pop_front());
      if (flush) q.delete();
      else if (push) q.push_back({in_rd_we, in_rd, in_result});
      if (push && in_flag_we) m_flags = {in_z, in_v, in_n};
      m_brv = br_eval;
      if (br_eval) m_brt = m_cond(br_cond, ef);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; in_result = '0; in_z = 1'b0; in_v = 1'b0; in_n = 1'b0;
    in_flag_we = 1'b0; in_rd = 3'd0; in_rd_we = 1'b0; out_ready = 1'b0;
    flush = 1'b0; br_eval = 1'b0; br_cond = 3'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1; in_flag_we = 1'b1; in_z = 1'b1; in_result = 16'h5A5A; br_eval = 1'b1;
    out_ready = 1'b1; flush = 1'b1;
    tick();
    tick();
    n_vec++; if (ready_obs !== 1'b0) begin n_err++; $display("FAIL reset_in_ready got %b want 0", ready_obs); end
    idle_inputs();
    rst = 1'b0;
    #1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_vec++; if (flags !== 3'b000) begin n_err++; $display("FAIL reset_flags got %b want 000", flags); end
    n_vec++; if (br_valid !== 1'b0 || br_taken !== 1'b0) begin n_err++; $display("FAIL reset_br got %b%b want 00", br_valid, br_taken); end
    n_vec++; if (out_result !== 16'h0000 || out_rd !== 3'd0 || out_rd_we !== 1'b0) begin
      n_err++; $display("FAIL reset_out_data got %h/%0d/%b want 0000/0/0", out_result, out_rd, out_rd_we); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_release_ready got %b want 1", in_ready); end
  endtask

  task automatic test_streaming();
    logic [W-1:0] vals[3];
    vals[0] = 16'h0001; vals[1] = 16'h0002; vals[2] = 16'h0003;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_result = vals[i]; in_rd = 3'(i + 1); in_rd_we = 1'b1;
      tick();
      n_vec++; if (ready_obs !== 1'b1) begin n_err++; $display("FAIL stream_ready[%0d] got %b want 1", i, ready_obs); end
      n_vec++; if (out_valid !== 1'b1 || out_result !== vals[i] || out_rd !== 3'(i + 1)) begin
        n_err++; $display("FAIL stream_out[%0d] got v=%b %h rd=%0d want v=1 %h rd=%0d", i, out_valid, out_result, out_rd, vals[i], i + 1); end
    end
    idle_inputs();
    out_ready = 1'b1;
    tick();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL stream_drain got %b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    idle_inputs();
    in_valid = 1'b1; in_result = 16'hAAAA;
    tick();
    in_result = 16'hBBBB;
    tick();
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_full_ready got %b want 0", in_ready); end
    in_result = 16'hCCCC;
    tick();
    n_vec++; if (ready_obs !== 1'b0) begin n_err++; $display("FAIL bp_refuse got %b want 0", ready_obs); end
    n_vec++; if (out_valid !== 1'b1 || out_result !== 16'hAAAA) begin n_err++; $display("FAIL bp_hold got v=%b %h want v=1 aaaa", out_valid, out_result); end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    n_vec++; if (out_valid !== 1'b1 || out_result !== 16'hBBBB) begin n_err++; $display("FAIL bp_pop1 got v=%b %h want v=1 bbbb", out_valid, out_result); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_back got %b want 1", in_ready); end
    tick();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_pop2 got %b want 0", out_valid); end
  endtask

  task automatic test_flag_fwd();
    idle_inputs();
    out_ready = 1'b1;
    in_valid = 1'b1; in_flag_we = 1'b1; in_z = 1'b0; in_v = 1'b1; in_n = 1'b0;
    br_eval = 1'b1; br_cond = 3'b010;
    tick();
    n_vec++; if (br_valid !== 1'b1 || br_taken !== 1'b1) begin n_err++; $display("FAIL fwd_br got %b%b want 11", br_valid, br_taken); end
    n_vec++; if (flags !== 3'b010) begin n_err++; $display("FAIL fwd_flags got %b want 010", flags); end
    idle_inputs();
    out_ready = 1'b1;
    tick();
    n_vec++; if (br_valid !== 1'b0 || br_taken !== 1'b1) begin n_err++; $display("FAIL br_hold got %b%b want 01", br_valid, br_taken); end
  endtask

  task automatic test_flush();
    idle_inputs();
    in_valid = 1'b1; in_result = 16'h1111;
    tick();
    in_result = 16'h2222;
    tick();
    in_result = 16'h3333; flush = 1'b1; in_flag_we = 1'b1; in_z = 1'b1;
    tick();
    idle_inputs();
    #1;
    n_vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL flush_state got v=%b r=%b want v=0 r=1", out_valid, in_ready); end
    n_vec++; if (flags !== 3'b010) begin n_err++; $display("FAIL flush_flags got %b want 010", flags); end
  endtask

  task automatic test_reset_midstream();
    idle_inputs();
    in_valid = 1'b1; in_result = 16'h4444; in_flag_we = 1'b1; in_z = 1'b1;
    tick();
    in_flag_we = 1'b0; in_z = 1'b0; in_result = 16'h5555;
    tick();
    n_vec++; if (flags !== 3'b100 || in_ready !== 1'b0) begin n_err++; $display("FAIL mid_setup got f=%b r=%b want f=100 r=0", flags, in_ready); end
    rst = 1'b1; in_flag_we = 1'b1; in_z = 1'b1; br_eval = 1'b1;
    tick();
    rst = 1'b0;
    idle_inputs();
    #1;
    n_vec++; if (out_valid !== 1'b0 || flags !== 3'b000 || br_valid !== 1'b0 || out_result !== 16'h0000) begin
      n_err++; $display("FAIL mid_reset got v=%b f=%b bv=%b r=%h want 0 000 0 0000", out_valid, flags, br_valid, out_result); end
  endtask

  task automatic test_cond_sweep();
    logic [7:0] exp_seq;
    exp_seq = 8'b1010_0100;
    idle_inputs();
    out_ready = 1'b1;
    in_valid = 1'b1; in_flag_we = 1'b1; in_z = 1'b1; in_v = 1'b0; in_n = 1'b1;
    tick();
    idle_inputs();
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      br_eval = 1'b1; br_cond = 3'(c);
      tick();
      n_vec++; if (br_valid !== 1'b1 || br_taken !== exp_seq[7-c]) begin
        n_err++; $display("FAIL sweep[%0d] got %b%b want 1%b", c, br_valid, br_taken, exp_seq[7-c]); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      rst        = ($urandom_range(63) == 0);
      flush      = ($urandom_range(15) == 0);
      in_valid   = ($urandom_range(3) != 0);
      out_ready  = ($urandom_range(2) != 0);
      in_result  = W'($urandom);
      in_rd      = 3'($urandom);
      in_rd_we   = 1'($urandom);
      in_flag_we = 1'($urandom);
      in_z = 1'($urandom); in_v = 1'($urandom); in_n = 1'($urandom);
      br_eval    = 1'($urandom);
      br_cond    = 3'($urandom);
      tick();
      n_vec++; if (ready_obs !== m_ready_pre) begin n_err++; $display("FAIL rnd_ready[%0d] got %b want %b", i, ready_obs, m_ready_pre); end
      n_vec++; if (out_valid !== (q.size() > 0)) begin n_err++; $display("FAIL rnd_valid[%0d] got %b want %b", i, out_valid, q.size() > 0); end
      if (q.size() > 0) begin
        n_vec++; if ({out_rd_we, out_rd, out_result} !== q[0]) begin
          n_err++; $display("FAIL rnd_head[%0d] got %h want %h", i, {out_rd_we, out_rd, out_result}, q[0]); end
      end
      n_vec++; if (flags !== m_flags) begin n_err++; $display("FAIL rnd_flags[%0d] got %b want %b", i, flags, m_flags); end
      n_vec++; if (br_valid !== m_brv || br_taken !== m_brt) begin
        n_err++; $display("FAIL rnd_br[%0d] got %b%b want %b%b", i, br_valid, br_taken, m_brv, m_brt); end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_streaming();
    test_backpressure();
    test_flag_fwd();
    test_flush();
    test_reset_midstream();
    test_cond_sweep();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
